// File: rtl/serial_cmd_initiator.sv
// Host-side initiator for the byte-serial command protocol: sends opcode/arg over UART, packs response bytes into words.
// Optional receive-gap timeout is enabled by defining SERCMD_TIMEOUT_EN.
module serial_cmd_initiator #(
  parameter int TIMEOUT_CYCLES     = 5000000,
  parameter int VERSION_RESP_BYTES = 1,
  parameter int HIST_RESP_BYTES    = 544
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic        txBusy,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        rxReady,
  input  logic [7:0]  rxData,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [7:0]  word_index,
  output logic        done,
  output logic        err,
  output logic [7:0]  stray_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TX_OP   = 3'd1;
  localparam logic [2:0] S_GAP_OP  = 3'd2;
  localparam logic [2:0] S_TX_ARG  = 3'd3;
  localparam logic [2:0] S_GAP_ARG = 3'd4;
  localparam logic [2:0] S_RECV    = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  logic [2:0]  state, state_nx;
  logic [7:0]  op_q, arg_q, last_tx;
  logic        is_arg1, is_resp;
  logic        cls_arg1, cls_resp;
  logic [9:0]  resp_total, byte_cnt;
  logic [31:0] word_acc, acc_nx;
  logic [1:0]  lane;
  logic        last_word;
  logic        accept, tx_fire, rx_take, final_byte, tmo_hit;

  assign accept     = cmd_valid && cmd_ready;
  assign tx_fire    = ((state == S_TX_OP) || (state == S_TX_ARG)) && !txBusy;
  // Once the closing word is pending, further bytes are not part of this response.
  assign rx_take    = (state == S_RECV) && rxReady && !last_word;
  assign lane       = byte_cnt[1:0];
  assign acc_nx     = word_acc | (32'(rxData) << {lane, 3'b000});
  assign final_byte = ((byte_cnt + 10'd1) == resp_total);

  assign cls_arg1 = cmd_op inside {8'd1, 8'd2, 8'd5, 8'd6, 8'd7};
  assign cls_resp = (cmd_op == 8'd0) || (cmd_op == 8'd10);

  assign txStart = tx_fire;
  assign txData  = tx_fire ? ((state == S_TX_ARG) ? arg_q : op_q) : last_tx;
  assign done    = (state == S_FINISH);

`ifdef SERCMD_TIMEOUT_EN
  logic [31:0] gap_cnt;
  logic        err_q;

  assign tmo_hit = (state == S_RECV) && !last_word && !rxReady &&
                   (gap_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign err     = done && err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != S_RECV || rxReady)
        gap_cnt <= '0;
      else if (gap_cnt != 32'(TIMEOUT_CYCLES - 1))
        gap_cnt <= gap_cnt + 32'd1;
      if (accept)
        err_q <= 1'b0;
      else if (tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept) state_nx = S_TX_OP;
      S_TX_OP:   if (!txBusy) state_nx = S_GAP_OP;
      S_GAP_OP:  state_nx = is_arg1 ? S_TX_ARG : (is_resp ? S_RECV : S_FINISH);
      S_TX_ARG:  if (!txBusy) state_nx = S_GAP_ARG;
      S_GAP_ARG: state_nx = is_resp ? S_RECV : S_FINISH;
      // Leave only after the closing word strobe, so done always follows the last word.
      S_RECV: begin
        if (word_valid && last_word)
          state_nx = S_FINISH;
        else if (tmo_hit && lane == 2'd0)
          state_nx = S_FINISH;
      end
      S_FINISH:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      op_q        <= '0;
      arg_q       <= '0;
      last_tx     <= '0;
      is_arg1     <= 1'b0;
      is_resp     <= 1'b0;
      resp_total  <= '0;
      byte_cnt    <= '0;
      word_acc    <= '0;
      last_word   <= 1'b0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_index  <= '0;
      stray_count <= '0;
    end else begin
      state      <= state_nx;
      cmd_ready  <= (state_nx == S_IDLE);
      word_valid <= 1'b0;

      if (accept) begin
        op_q       <= cmd_op;
        arg_q      <= cmd_arg;
        is_arg1    <= cls_arg1;
        is_resp    <= cls_resp;
        resp_total <= (cmd_op == 8'd0) ? 10'(VERSION_RESP_BYTES) : 10'(HIST_RESP_BYTES);
        byte_cnt   <= '0;
        word_acc   <= '0;
        word_index <= '0;
        last_word  <= 1'b0;
      end

      if (tx_fire)
        last_tx <= txData;

      if (word_valid)
        word_index <= word_index + 8'd1;

      if (rx_take) begin
        byte_cnt <= byte_cnt + 10'd1;
        if (lane == 2'd3 || final_byte) begin
          word_valid <= 1'b1;
          word_data  <= acc_nx;
          word_acc   <= '0;
          last_word  <= final_byte;
        end else begin
          word_acc <= acc_nx;
        end
      end

      // A timeout flushes any partial word, zero-padded, as the closing word.
      if (tmo_hit) begin
        last_word <= 1'b1;
        if (lane != 2'd0) begin
          word_valid <= 1'b1;
          word_data  <= word_acc;
          word_acc   <= '0;
        end
      end

      if (rxReady && state != S_RECV && stray_count != 8'hFF)
        stray_count <= stray_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Self-checking bench for serial_cmd_initiator: directed command sequence with word/tx scoreboards.
// Timeout scenario runs only when SERCMD_TIMEOUT_EN is defined.
module tb_serial_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic        rxReady;
  logic [7:0]  rxData;
  logic        word_valid;
  logic [31:0] word_data;
  logic [7:0]  word_index;
  logic        done;
  logic        err;
  logic [7:0]  stray_count;

  int total = 0;
  int bad = 0;
  int tx_cnt = 0;
  int word_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_alone = 0;
  int words_at_done = 0;

  logic [39:0] exp_words[$];
  logic [7:0]  exp_tx[$];
  logic [39:0] mon_w;
  logic [7:0]  mon_t;

`ifdef SERCMD_TIMEOUT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  always #5 clk = ~clk;

  serial_cmd_initiator #(
    .TIMEOUT_CYCLES(100),
    .VERSION_RESP_BYTES(1),
    .HIST_RESP_BYTES(544)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .txBusy(txBusy),
    .txStart(txStart),
    .txData(txData),
    .rxReady(rxReady),
    .rxData(rxData),
    .word_valid(word_valid),
    .word_data(word_data),
    .word_index(word_index),
    .done(done),
    .err(err),
    .stray_count(stray_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (word_valid) begin
        word_cnt++;
        checkOutput("word_expected", 32'(exp_words.size() != 0), 32'd1);
        if (exp_words.size() != 0) begin
          mon_w = exp_words.pop_front();
          checkOutput("word_data", word_data, mon_w[31:0]);
          checkOutput("word_index", 32'(word_index), 32'(mon_w[39:32]));
        end
      end
      if (txStart) begin
        tx_cnt++;
        checkOutput("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) begin
          mon_t = exp_tx.pop_front();
          checkOutput("tx_data", 32'(txData), 32'(mon_t));
        end
      end
      if (done) begin
        done_cnt++;
        words_at_done = word_cnt;
      end
      if (err) begin
        err_cnt++;
        if (!done) err_alone++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] arg);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_tx.push_back(op);
    if (op inside {8'd1, 8'd2, 8'd5, 8'd6, 8'd7})
      exp_tx.push_back(arg);
  endtask

  task automatic waitTx(input int target, input string tag);
    int n = 0;
    while (tx_cnt < target && n < 200) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(tx_cnt), 32'(target));
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic sendByte(input logic [7:0] b);
    rxReady = 1'b1;
    rxData  = b;
    tick();
    rxReady = 1'b0;
    tick();
  endtask

  task automatic pushHistWords(input int nwords);
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < 4; k++)
        w[8*k +: 8] = 8'((4 * i + k) % 256);
      exp_words.push_back({8'(i), w});
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 8'h00;
    cmd_arg   = 8'h00;
    txBusy    = 1'b0;
    rxReady   = 1'b0;
    rxData    = 8'h00;
    repeat (3) tick();

    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_word_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_tx_start", 32'(txStart), 32'd0);
    checkOutput("rst_tx_data", 32'(txData), 32'd0);
    checkOutput("rst_stray", 32'(stray_count), 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Opcode 0: version read
    applyStimulus(8'd0, 8'h00);
    waitTx(1, "op0_tx_count");
    tick();
    exp_words.push_back({8'd0, 32'h0000000D});
    sendByte(8'h0D);
    waitDone(1, 50, "op0_done");
    checkOutput("op0_words", 32'(word_cnt), 32'd1);
    checkOutput("op0_err", 32'(err_cnt), 32'd0);
    checkOutput("op0_stray", 32'(stray_count), 32'd0);

    // Opcode 1 with arg; transmitter stays busy before the argument byte
    applyStimulus(8'd1, 8'h0A);
    waitTx(2, "op1_first_tx");
    txBusy = 1'b1;
    repeat (20) tick();
    checkOutput("op1_arg_held_while_busy", 32'(tx_cnt), 32'd2);
    txBusy = 1'b0;
    waitTx(3, "op1_arg_tx");
    waitDone(2, 50, "op1_done");
    checkOutput("op1_no_words", 32'(word_cnt), 32'd1);
    checkOutput("op1_tx_total", 32'(tx_cnt), 32'd3);

    // Opcode 10: 544-byte histogram
    applyStimulus(8'd10, 8'h00);
    waitTx(4, "op10_tx");
    tick();
    pushHistWords(136);
    for (int i = 0; i < 544; i++)
      sendByte(i[7:0]);
    waitDone(3, 50, "op10_done");
    checkOutput("op10_words", 32'(word_cnt), 32'd137);
    checkOutput("op10_words_before_done", 32'(words_at_done), 32'd137);

    // Opcode 3 with stray bytes in IDLE, then stray saturation
    repeat (5) sendByte(8'hEE);
    checkOutput("stray_5", 32'(stray_count), 32'd5);
    applyStimulus(8'd3, 8'h00);
    waitTx(5, "op3_tx");
    waitDone(4, 50, "op3_done");
    checkOutput("op3_tx_total", 32'(tx_cnt), 32'd5);
    checkOutput("op3_stray_kept", 32'(stray_count), 32'd5);
    repeat (300) sendByte(8'h55);
    checkOutput("stray_saturated", 32'(stray_count), 32'd255);

    // Reset in the middle of an opcode-10 response
    applyStimulus(8'd10, 8'h00);
    waitTx(6, "op10b_tx");
    tick();
    pushHistWords(25);
    for (int i = 0; i < 100; i++)
      sendByte(i[7:0]);
    checkOutput("op10b_words_before_reset", 32'(word_cnt), 32'd162);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_word_index", 32'(word_index), 32'd0);
    checkOutput("midrst_word_data", 32'(word_data), 32'd0);
    checkOutput("midrst_stray", 32'(stray_count), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_queue_drained", 32'(exp_words.size()), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    applyStimulus(8'd0, 8'h00);
    waitTx(7, "op0b_tx");
    tick();
    exp_words.push_back({8'd0, 32'h0000005A});
    sendByte(8'h5A);
    waitDone(5, 50, "op0b_done");
    checkOutput("op0b_words", 32'(word_cnt), 32'd163);

`ifdef SERCMD_TIMEOUT_EN
    // Short opcode-10 response ending in a receive timeout
    applyStimulus(8'd10, 8'h00);
    waitTx(8, "tmo_tx");
    tick();
    exp_words.push_back({8'd0, 32'h14131211});
    exp_words.push_back({8'd1, 32'h00001615});
    for (int i = 0; i < 6; i++)
      sendByte(8'h11 + 8'(i));
    waitDone(6, 300, "tmo_done");
    checkOutput("tmo_words", 32'(word_cnt), 32'd165);
    checkOutput("tmo_err_alone", 32'(err_alone), 32'd0);
`endif

    checkOutput("err_total", 32'(err_cnt), 32'(EXP_ERR));
    checkOutput("words_left", 32'(exp_words.size()), 32'd0);
    checkOutput("tx_left", 32'(exp_tx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
